mux_nto1_skid: RTL and testbench
================================

// Module: mux_nto1_skid
// PURPOSE
//  Parametrised N-to-1 datapath selector with a registered output stage and a
//  2-entry valid/ready skid buffer. Successor to the combinational 2:1 mux.
//  Used between pipeline stages (operand/forwarding select, writeback select)
//  where the selected value must be registered and back-pressure-safe.
//  Supports a flush that drops in-flight data.
// PARAMETERS
//  size      32  data width of each channel, in bits (>=1)
//  channels  4   number of input channels (>=2, not required to be a power of 2)
//  SEL_W     localparam = $clog2(channels); width of select_i
// PORTS
//  clk_i      in   1               clock; all state updates on the rising edge
//  rst_i      in   1               async reset, active-low
//  data_i     in   size*channels   flattened channels; ch k = data_i[k*size +: size]
//  select_i   in   SEL_W           binary channel index
//  valid_i    in   1               upstream beat valid
//  ready_o    out  1               block can accept a beat this cycle
//  flush_i    in   1               synchronous flush of all held beats
//  data_o     out  size            selected, registered data
//  valid_o    out  1               data_o holds a valid beat
//  ready_i    in   1               downstream accepts the data_o beat
//  sel_err_o  out  1               sticky flag: a beat was accepted with select_i >= channels
// BEHAVIOUR
//  Reset (rst_i=0, asynchronous): main and skid entries invalid, data regs = 0,
//   data_o=0, valid_o=0, sel_err_o=0; ready_o=1 while and after reset.
//  Selection: value = channel[select_i], sampled only on accept
//   (valid_i & ready_o). If select_i >= channels, value = 0 and sel_err_o sets.
//  Storage: main entry (drives data_o/valid_o) + skid entry.
//   ready_o = ~skid_valid (pure register output, no combinational path from ready_i).
//  Latency: an accepted beat appears on data_o the next cycle if main is empty or
//   drains the same cycle; otherwise it enters skid.
//  Per-cycle update (acc = valid_i & ready_o, pop = valid_o & ready_i):
//   - main empty or pop, skid empty: main <= acc ? new : empty.
//   - main empty or pop, skid full: main <= skid; skid <= acc ? new : empty
//     (acc is impossible here because ready_o=0).
//   - main full, no pop: skid <= acc ? new : skid.
//  Order is strictly FIFO; no beat is duplicated or lost without a flush.
//  Both entries full: ready_o=0; valid_i is ignored; select_i/data_i are don't-care.
//  Flush: flush_i=1 invalidates main and skid at the edge.
//   The same-cycle valid_i beat is dropped and not counted as accepted.
//   sel_err_o is cleared; the next cycle valid_o=0 and ready_o=1.
//   Flush has priority over pop and accept. Data regs keep their old values, masked by valid_o=0.
//  sel_err_o: set on an accept with an out-of-range select. It is cleared only by reset or flush.
//   Set takes priority over the flush clear if both occur in the same cycle? No: the flush drops the beat,
//   so flush wins.
//  data_o is stable while valid_o=1 and ready_i=0 (AXI-style hold rule).
//  Asserting reset mid-transfer discards all beats immediately; no partial state survives.
//  Throughput: 1 beat/cycle sustained when ready_i=1.
// TESTING
//  1. Reset: rst_i=0 with valid_i=1 -> valid_o=0, data_o=0, ready_o=1, sel_err_o=0.
//  2. Streaming: channels=4, ch2=32'hDEAD_BEEF, select_i=2, valid_i=1, ready_i=1
//     -> next cycle data_o=DEADBEEF, valid_o=1; 1 beat/cycle over 16 beats, in order.
//  3. Back-pressure: ready_i=0, send beats A,B,C -> A on data_o, B in skid,
//     ready_o=0 after B, C held off. Raise ready_i -> A, B, C emerge in order, none lost.
//  4. Flush: two beats held, flush_i=1 with valid_i=1 (beat D) -> next cycle
//     valid_o=0, ready_o=1; D never appears on data_o.
//  5. Bad select: channels=3, select_i=3, accept -> data_o=0, valid_o=1, sel_err_o=1
//     stays high through later good beats; a flush clears it to 0.
//  6. Async reset mid-stream: drop rst_i between edges -> outputs go to reset values
//     immediately, with no clock edge needed.

Source files
------------

// File: rtl/mux_nto1_skid.sv
// N-to-1 channel selector feeding a registered main entry plus a one-entry skid,
// giving a back-pressure-safe valid/ready stage with flush and a sticky bad-select flag.
module mux_nto1_skid #(
    parameter  int size     = 32,
    parameter  int channels = 4,
    localparam int SEL_W    = $clog2(channels)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [size*channels-1:0] data_i,
    input  logic [SEL_W-1:0]         select_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic [size-1:0]          data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     sel_err_o
);

    logic [size-1:0] main_data;
    logic [size-1:0] skid_data;
    logic            main_valid;
    logic            skid_valid;
    logic            sel_err;
    logic [size-1:0] sel_val;
    logic            bad_sel;
    logic            acc;
    logic            pop;

    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < channels; k++) begin
            if (select_i == SEL_W'(k)) begin
                sel_val = data_i[k*size +: size];
            end
        end
        // Extra bit so the compare also works when channels is a power of two.
        bad_sel = ({1'b0, select_i} >= (SEL_W+1)'(channels));
    end

    assign acc = valid_i & ~skid_valid;
    assign pop = main_valid & ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_data  <= '0;
            skid_data  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            if (acc && bad_sel) begin
                sel_err <= 1'b1;
            end
            if (!main_valid || pop) begin
                if (skid_valid) begin
                    // Skid drains into main; no accept can coincide since ready_o is low.
                    main_data  <= skid_data;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= acc;
                    if (acc) begin
                        main_data <= sel_val;
                    end
                end
            end else if (acc) begin
                skid_data  <= sel_val;
                skid_valid <= 1'b1;
            end
        end
    end

    assign ready_o   = ~skid_valid;
    assign data_o    = main_data;
    assign valid_o   = main_valid;
    assign sel_err_o = sel_err;

endmodule

// File: tb/tb_mux_nto1_skid.sv
// Bench for mux_nto1_skid: a 4-channel and a 3-channel instance share stimulus and are
// compared every cycle against a small occupancy/FIFO model, plus literal spot checks.
module tb_mux_nto1_skid;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_i = 1'b0;
    logic [W-1:0]   ch [4];
    logic [4*W-1:0] data_bus;
    logic [1:0]     sel;
    logic           valid_i, ready_i, flush_i;

    logic [W-1:0] data4, data3;
    logic         valid4, valid3, ready4, ready3, err4, err3;

    int checks = 0;
    int errors = 0;

    // Model: per instance, number of held beats (0..2), their values oldest first, sticky flag.
    int           cnt [2];
    logic [W-1:0] ent [2][2];
    bit           err_m [2];
    int           nch [2] = '{4, 3};

    assign data_bus = {ch[3], ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    mux_nto1_skid #(.size(W), .channels(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_bus), .select_i(sel),
        .valid_i(valid_i), .ready_o(ready4), .flush_i(flush_i),
        .data_o(data4), .valid_o(valid4), .ready_i(ready_i), .sel_err_o(err4)
    );

    mux_nto1_skid #(.size(W), .channels(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_bus[3*W-1:0]), .select_i(sel),
        .valid_i(valid_i), .ready_o(ready3), .flush_i(flush_i),
        .data_o(data3), .valid_o(valid3), .ready_i(ready_i), .sel_err_o(err3)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input int n);
        return (int'(sel) < n) ? ch[sel] : '0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            cnt[m] = 0;
            err_m[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit acc, pop;
        for (int m = 0; m < 2; m++) begin
            if (!rst_i || flush_i) begin
                cnt[m] = 0;
                err_m[m] = 1'b0;
            end else begin
                acc = valid_i && (cnt[m] < 2);
                pop = (cnt[m] > 0) && ready_i;
                if (pop) begin
                    ent[m][0] = ent[m][1];
                    cnt[m]--;
                end
                if (acc) begin
                    ent[m][cnt[m]] = pick(nch[m]);
                    cnt[m]++;
                    if (int'(sel) >= nch[m]) err_m[m] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_inst(input int m, input logic v, input logic r, input logic e,
                                input logic [W-1:0] d);
        check($sformatf("valid_o[%0d]", nch[m]), W'(v), W'(cnt[m] > 0));
        check($sformatf("ready_o[%0d]", nch[m]), W'(r), W'(cnt[m] < 2));
        check($sformatf("sel_err_o[%0d]", nch[m]), W'(e), W'(err_m[m]));
        if (cnt[m] > 0) check($sformatf("data_o[%0d]", nch[m]), d, ent[m][0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_inst(0, valid4, ready4, err4, data4);
        compare_inst(1, valid3, ready3, err3, data3);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) ch[k] = 32'h0000_0100 * (k + 1);
        sel = 2'd2; valid_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
        model_reset();

        // Reset with valid_i high.
        cycle();
        check("rst valid_o", W'(valid4), 0);
        check("rst data_o", data4, 0);
        check("rst ready_o", W'(ready4), 1);
        check("rst sel_err_o", W'(err3), 0);
        rst_i = 1'b1;

        // Streaming on channel 2, one beat per cycle.
        for (int i = 0; i < 16; i++) begin
            ch[2] = (i == 0) ? 32'hDEAD_BEEF : 32'h0000_1000 + W'(i);
            cycle();
            check("stream valid_o", W'(valid4), 1);
            check("stream data_o", data4, (i == 0) ? 32'hDEAD_BEEF : 32'h0000_1000 + W'(i));
        end
        valid_i = 1'b0;
        cycle();

        // Back-pressure: A to main, B to skid, C held off until drained.
        ready_i = 1'b0; valid_i = 1'b1; sel = 2'd0;
        ch[0] = 32'hA0A0_0001; cycle();
        check("bp A data_o", data4, 32'hA0A0_0001);
        check("bp ready after A", W'(ready4), 1);
        ch[0] = 32'hB0B0_0002; cycle();
        check("bp ready after B", W'(ready4), 0);
        ch[0] = 32'hC0C0_0003; cycle();
        check("bp hold A", data4, 32'hA0A0_0001);
        ready_i = 1'b1; cycle();
        check("bp B out", data4, 32'hB0B0_0002);
        cycle();
        check("bp C out", data4, 32'hC0C0_0003);
        valid_i = 1'b0; cycle();
        check("bp drained", W'(valid4), 0);

        // Flush with both entries full and a same-cycle beat D.
        ready_i = 1'b0; valid_i = 1'b1;
        ch[0] = 32'hE1E1_0001; cycle();
        ch[0] = 32'hE2E2_0002; cycle();
        flush_i = 1'b1; ch[0] = 32'hD00D_0D0D; cycle();
        check("flush valid_o", W'(valid4), 0);
        check("flush ready_o", W'(ready4), 1);
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) cycle();

        // Out-of-range select on the 3-channel instance.
        valid_i = 1'b1; sel = 2'd3; ch[3] = 32'h3333_3333; cycle();
        check("badsel data_o", data3, 0);
        check("badsel valid_o", W'(valid3), 1);
        check("badsel sel_err_o", W'(err3), 1);
        check("badsel ok on 4ch", W'(err4), 0);
        sel = 2'd1; repeat (2) cycle();
        check("badsel sticky", W'(err3), 1);
        valid_i = 1'b0; flush_i = 1'b1; cycle();
        check("badsel flush clear", W'(err3), 0);
        flush_i = 1'b0;

        // Asynchronous reset between edges.
        valid_i = 1'b1; ready_i = 1'b0; sel = 2'd1;
        repeat (2) cycle();
        sel = 2'd3; ready_i = 1'b1; cycle();
        @(posedge clk);
        model_step();
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        check("async valid_o", W'(valid4), 0);
        check("async data_o", data4, 0);
        check("async ready_o", W'(ready4), 1);
        check("async sel_err_o", W'(err3), 0);
        @(negedge clk);
        rst_i = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            sel     = 2'($urandom_range(0, 3));
            flush_i = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 4; k++) ch[k] = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
